// File: rtl/rgmii_speed_ctrl.sv
// RGMII link/speed controller: debounces in-band idle status and sequences speed, duplex, link_up and the MAC reset hold window.
// Define RGMII_SPEED_CTRL_STATS_EN to add saturating stat_speed_changes / stat_invalid_status counters.
module rgmii_speed_ctrl #(
   parameter int unsigned STABLE_COUNT  = 16,
   parameter int unsigned HOLD_CYCLES   = 64,
   parameter logic [1:0]  DEFAULT_SPEED = 2'b10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  gmii_rxd,
   input  logic        gmii_rx_dv,
   input  logic        gmii_rx_er,
   input  logic        cfg_force_en,
   input  logic [1:0]  cfg_force_speed,
   input  logic        cfg_force_duplex,
   output logic [1:0]  speed,
   output logic        link_up,
   output logic        full_duplex,
   output logic        mac_rst,
   output logic        speed_change
`ifdef RGMII_SPEED_CTRL_STATS_EN
   ,
   output logic [15:0] stat_speed_changes,
   output logic [15:0] stat_invalid_status
`endif
);

   localparam logic [7:0]  STABLE_MAX = 8'(STABLE_COUNT);
   localparam logic [15:0] HOLD_LOAD  = 16'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {NO_LINK, HOLD, LINKED} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cand_q, cand_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] hold_q, hold_d;
   logic [1:0]  speed_q, speed_d;
   logic        dup_q, dup_d;
   logic        chg_q;

   logic        idle;
   logic        invalid;
   logic        qualified;
   logic [3:0]  smp;
   logic        tgt_link;
   logic        tgt_dup;
   logic [1:0]  tgt_speed;
   logic [1:0]  force_speed;
   logic        unused_rxd_hi;

   assign unused_rxd_hi = ^gmii_rxd[7:4];

   // Sample layout: [0] link, [2:1] speed, [3] duplex
   assign smp         = gmii_rxd[3:0];
   assign idle        = !gmii_rx_dv && !gmii_rx_er;
   assign invalid     = smp[0] && (smp[2:1] == 2'b11);
   assign qualified   = (cnt_q == STABLE_MAX);
   assign force_speed = (cfg_force_speed == 2'b11) ? 2'b10 : cfg_force_speed;
   assign tgt_link    = cand_q[0];
   assign tgt_speed   = cfg_force_en ? force_speed : cand_q[2:1];
   assign tgt_dup     = cfg_force_en ? cfg_force_duplex : cand_q[3];

   always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      if (idle) begin
         if (invalid) begin
            cnt_d = 8'd0;
         end else if (smp == cand_q) begin
            if (cnt_q != STABLE_MAX) cnt_d = cnt_q + 8'd1;
         end else begin
            cand_d = smp;
            cnt_d  = 8'd1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      speed_d = speed_q;
      hold_d  = hold_q;
      dup_d   = (qualified && tgt_link) ? tgt_dup : dup_q;
      case (state_q)
         NO_LINK: begin
            if (qualified && tgt_link) begin
               speed_d = tgt_speed;
               hold_d  = HOLD_LOAD;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (qualified && !tgt_link) begin
               state_d = NO_LINK;
            end else if (qualified && (tgt_speed != speed_q)) begin
               speed_d = tgt_speed;
               hold_d  = HOLD_LOAD;
            end else if (hold_q == 16'd0) begin
               state_d = LINKED;
            end else begin
               hold_d = hold_q - 16'd1;
            end
         end
         LINKED: begin
            if (qualified && !tgt_link) begin
               state_d = NO_LINK;
            end else if (qualified && (tgt_speed != speed_q)) begin
               speed_d = tgt_speed;
               hold_d  = HOLD_LOAD;
               state_d = HOLD;
            end
         end
         default: state_d = NO_LINK;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= NO_LINK;
         cand_q  <= 4'd0;
         cnt_q   <= 8'd0;
         hold_q  <= 16'd0;
         speed_q <= DEFAULT_SPEED;
         dup_q   <= 1'b0;
         chg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         speed_q <= speed_d;
         dup_q   <= dup_d;
         chg_q   <= (speed_d != speed_q);
      end
   end

   assign speed        = speed_q;
   assign full_duplex  = dup_q;
   assign link_up      = (state_q == LINKED);
   assign mac_rst      = (state_q != LINKED);
   assign speed_change = chg_q;

`ifdef RGMII_SPEED_CTRL_STATS_EN
   logic [15:0] stat_chg_q;
   logic [15:0] stat_inv_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_chg_q <= 16'd0;
         stat_inv_q <= 16'd0;
      end else begin
         if ((speed_d != speed_q) && (stat_chg_q != 16'hFFFF)) stat_chg_q <= stat_chg_q + 16'd1;
         if (idle && invalid && (stat_inv_q != 16'hFFFF)) stat_inv_q <= stat_inv_q + 16'd1;
      end
   end

   assign stat_speed_changes  = stat_chg_q;
   assign stat_invalid_status = stat_inv_q;
`endif

endmodule

// File: tb/tb_rgmii_speed_ctrl.sv
// Bench for rgmii_speed_ctrl: directed plan scenarios plus randomized idle/frame traffic, checked every cycle against a window-based status model.
module tb_rgmii_speed_ctrl;

   localparam int S = 16;
   localparam int H = 64;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] gmii_rxd = 8'h00;
   logic       gmii_rx_dv = 1'b0;
   logic       gmii_rx_er = 1'b0;
   logic       cfg_force_en = 1'b0;
   logic [1:0] cfg_force_speed = 2'b00;
   logic       cfg_force_duplex = 1'b0;
   logic [1:0] speed;
   logic       link_up;
   logic       full_duplex;
   logic       mac_rst;
   logic       speed_change;

   always #5 clk = ~clk;

   rgmii_speed_ctrl dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .gmii_rxd         (gmii_rxd),
      .gmii_rx_dv       (gmii_rx_dv),
      .gmii_rx_er       (gmii_rx_er),
      .cfg_force_en     (cfg_force_en),
      .cfg_force_speed  (cfg_force_speed),
      .cfg_force_duplex (cfg_force_duplex),
      .speed            (speed),
      .link_up          (link_up),
      .full_duplex      (full_duplex),
      .mac_rst          (mac_rst),
      .speed_change     (speed_change)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the last S idle samples decide qualification; hold expiry is an absolute cycle number.
   localparam int M_DOWN = 0, M_HOLD = 1, M_UP = 2;
   int         m_state = M_DOWN;
   logic [1:0] m_speed = 2'b10;
   bit         m_dup = 1'b0;
   bit         m_chg = 1'b0;
   longint     cyc = 0;
   longint     rel = 0;
   logic [3:0] hist[$];

   function automatic bit valid_st(input logic [3:0] s);
      return !(s[0] && (s[2:1] == 2'b11));
   endfunction

   always @(posedge clk or negedge rst_n) begin
      bit         qual;
      bit         tl;
      bit         td;
      logic [3:0] c;
      logic [1:0] ts;
      logic [1:0] old;
      if (!rst_n) begin
         m_state = M_DOWN;
         m_speed = 2'b10;
         m_dup   = 1'b0;
         m_chg   = 1'b0;
         hist.delete();
      end else begin
         cyc++;
         qual = (hist.size() == S);
         if (qual) begin
            foreach (hist[i]) if (!valid_st(hist[i]) || hist[i] != hist[0]) qual = 1'b0;
         end
         c   = qual ? hist[S-1] : 4'h0;
         tl  = c[0];
         ts  = cfg_force_en ? ((cfg_force_speed == 2'b11) ? 2'b10 : cfg_force_speed) : c[2:1];
         td  = cfg_force_en ? cfg_force_duplex : c[3];
         old = m_speed;
         case (m_state)
            M_DOWN: if (qual && tl) begin
               m_speed = ts; m_dup = td; m_state = M_HOLD; rel = cyc + H;
            end
            M_HOLD: begin
               if (qual && !tl) m_state = M_DOWN;
               else if (qual && ts != m_speed) begin
                  m_speed = ts; m_dup = td; rel = cyc + H;
               end else begin
                  if (qual) m_dup = td;
                  if (cyc == rel) m_state = M_UP;
               end
            end
            default: begin
               if (qual && !tl) m_state = M_DOWN;
               else if (qual && ts != m_speed) begin
                  m_speed = ts; m_dup = td; m_state = M_HOLD; rel = cyc + H;
               end else if (qual) m_dup = td;
            end
         endcase
         m_chg = (m_speed != old);
         if (!gmii_rx_dv && !gmii_rx_er) begin
            hist.push_back(gmii_rxd[3:0]);
            if (hist.size() > S) void'(hist.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_speed", int'(speed), int'(m_speed));
         check("cyc_link_up", int'(link_up), int'(m_state == M_UP));
         check("cyc_mac_rst", int'(mac_rst), int'(m_state != M_UP));
         check("cyc_full_duplex", int'(full_duplex), int'(m_dup));
         check("cyc_speed_change", int'(speed_change), int'(m_chg));
      end
   end

   task automatic drive(input logic [7:0] b, input logic dv, input logic er);
      @(negedge clk);
      gmii_rxd   = b;
      gmii_rx_dv = dv;
      gmii_rx_er = er;
   endtask

   task automatic idle(input int n, input logic [7:0] b);
      repeat (n) drive(b, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] tbl[10] = '{8'h0D, 8'h0B, 8'h09, 8'h05, 8'h03, 8'h01, 8'h00, 8'h07, 8'h0F, 8'h02};

   initial begin
      @(posedge clk);
      chk_en = 1'b1;
      #1;
      check("rst_speed", int'(speed), 2);
      check("rst_link_up", int'(link_up), 0);
      check("rst_mac_rst", int'(mac_rst), 1);
      check("rst_full_duplex", int'(full_duplex), 0);
      check("rst_speed_change", int'(speed_change), 0);
      check("model_rst_speed", int'(m_speed), 2);
      @(negedge clk);
      rst_n = 1'b1;

      // Link up at 1G full duplex
      idle(16, 8'h0D);
      drive(8'h0D, 1'b0, 1'b0);
      after_edge();
      check("up_speed", int'(speed), 2);
      check("up_full_duplex", int'(full_duplex), 1);
      check("up_mac_rst_held", int'(mac_rst), 1);
      check("up_no_speed_change", int'(speed_change), 0);
      repeat (63) @(posedge clk);
      #1 check("up_mac_rst_last_hold", int'(mac_rst), 1);
      after_edge();
      check("up_link_up", int'(link_up), 1);
      check("up_mac_rst_release", int'(mac_rst), 0);
      check("model_linked", m_state, M_UP);

      // Duplex-only change
      idle(17, 8'h05);
      after_edge();
      check("dup_full_duplex", int'(full_duplex), 0);
      check("dup_mac_rst", int'(mac_rst), 0);
      check("dup_speed", int'(speed), 2);

      // 100M with a frame splitting the debounce run
      idle(15, 8'h03);
      for (int i = 0; i < 20; i++) drive(8'($urandom), 1'b1, 1'b0);
      drive(8'h03, 1'b0, 1'b0);
      @(posedge clk);
      after_edge();
      check("chg_speed", int'(speed), 1);
      check("chg_pulse", int'(speed_change), 1);
      check("chg_mac_rst", int'(mac_rst), 1);
      check("chg_link_up", int'(link_up), 0);
      after_edge();
      check("chg_pulse_end", int'(speed_change), 0);
      repeat (61) @(posedge clk);
      after_edge();
      check("chg_mac_rst_last_hold", int'(mac_rst), 1);
      after_edge();
      check("chg_link_up_back", int'(link_up), 1);

      // Link drop keeps speed
      idle(17, 8'h00);
      after_edge();
      check("drop_link_up", int'(link_up), 0);
      check("drop_mac_rst", int'(mac_rst), 1);
      check("drop_speed", int'(speed), 1);

      // Back to 1G, then force 10M, then invalid status
      idle(100, 8'h0D);
      after_edge();
      check("relink_link_up", int'(link_up), 1);
      check("relink_speed", int'(speed), 2);
      @(negedge clk);
      cfg_force_en = 1'b1;
      cfg_force_speed = 2'b00;
      cfg_force_duplex = 1'b1;
      after_edge();
      check("force_speed", int'(speed), 0);
      check("force_pulse", int'(speed_change), 1);
      check("force_mac_rst", int'(mac_rst), 1);
      idle(16, 8'h07);
      repeat (50) @(posedge clk);
      #1 check("force_link_up", int'(link_up), 1);
      check("force_speed_kept", int'(speed), 0);

      // Alternating status never qualifies
      @(negedge clk);
      cfg_force_en = 1'b0;
      do_reset();
      for (int i = 0; i < 200; i++) drive(((i / 8) % 2) ? 8'h0B : 8'h0D, 1'b0, 1'b0);
      after_edge();
      check("alt_link_up", int'(link_up), 0);
      check("alt_mac_rst", int'(mac_rst), 1);
      check("alt_speed", int'(speed), 2);
      check("alt_full_duplex", int'(full_duplex), 0);

      // Randomized traffic
      for (int it = 0; it < 160; it++) begin
         logic [7:0] b;
         int         len;
         b   = tbl[$urandom_range(9)] | {4'($urandom_range(15)), 4'h0};
         len = ($urandom_range(3) == 0) ? $urandom_range(150, 60) : $urandom_range(20, 1);
         if ($urandom_range(5) == 0) begin
            @(negedge clk);
            cfg_force_en     = 1'($urandom_range(1));
            cfg_force_speed  = 2'($urandom_range(3));
            cfg_force_duplex = 1'($urandom_range(1));
         end
         for (int j = 0; j < len; j++) begin
            if ($urandom_range(9) == 0) begin
               logic d;
               d = 1'($urandom_range(1));
               drive(8'($urandom), d, !d || 1'($urandom_range(1)));
            end else begin
               drive(b, 1'b0, 1'b0);
            end
         end
         if (it == 80) do_reset();
      end

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
